n64_rx: RTL and testbench
=========================

# n64_rx

Receiver for the N64 controller single-wire data line. After the host side finishes transmitting a poll command, this block is armed. It measures the low-pulse width of each incoming bit, deserializes the controller's 32-bit response MSB-first, checks for the stop bit and presents the word with a one-cycle valid strobe. It sits beside the command serializer on the same open-drain line and feeds the button-state logic.

## Interface
- `N`, 32: response length in bits.
- `THRESH`, 24: low-width decision threshold in clk cycles (2 µs at 12 MHz). Low < `THRESH` decodes as 1; low ≥ `THRESH` decodes as 0.
- `GLITCH`, 3: low pulses shorter than this many cycles are ignored.
- `TIMEOUT`, 1200: maximum cycles (100 µs at 12 MHz) allowed in any single wait or measurement before the frame is aborted.

- `clk` in 1: system clock; all logic on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle arm request, issued when the command transmit ends.
- `din` in 1: raw data line (pulled up; low = driven). Asynchronous to `clk`.
- `data` out N: last received word; first received bit is in `data[N-1]`.
- `valid` out 1: one-cycle strobe when `data` is updated.
- `busy` out 1: high from arm until frame end or abort.
- `err` out 1: one-cycle strobe on timeout abort.

## Operation
- `din` passes through a 2-flop synchronizer; all decisions use the synchronized signal `ds` and its registered copy, for edge detection.
- Reset (`rstn`=0 at a clk edge) forces:
  - state IDLE;
  - `data`=0, `valid`=0, `busy`=0, `err`=0;
  - bit counter 0, width counter 0, shift register 0;
  - synchronizer flops to 1.
- States:
  - IDLE: `busy`=0. `start`=1 → WAIT_FALL; clear bit count and width counter.
  - WAIT_FALL: `busy`=1. Width counter increments each cycle. A falling edge of `ds` → MEAS_LOW with counter reset to 1. Counter reaching `TIMEOUT` → ABORT.
  - MEAS_LOW: counter increments while `ds`=0.
    - On a rising edge with counter < `GLITCH`: discard the pulse, return to WAIT_FALL, and keep the bit count.
    - Otherwise: shift in (counter < `THRESH`) ? 1 : 0 at the LSB, shifting left, and increment the bit count.
    - If the bit count is now `N`: go to STOP_FALL. Else: go to WAIT_FALL.
    - Counter reaching `TIMEOUT` (line stuck low) → ABORT.
  - STOP_FALL: waits for the stop-bit falling edge, then goes to STOP_RISE. Timeout → ABORT.
  - STOP_RISE: on a rising edge, `data` ← shift register, `valid`=1 for one cycle, then IDLE. Stop-bit width is not decoded. Timeout → ABORT.
  - ABORT: `err`=1 for one cycle, then IDLE. `data` is left unchanged.
- Width counter saturates at `TIMEOUT`; its width is clog2(`TIMEOUT`+1).
- `start` while `busy`=1 is ignored; the frame continues.
- `start` in the same cycle as the IDLE return from STOP_RISE/ABORT is ignored, because `start` is only sampled in IDLE.
- Edges of `din` while in IDLE are ignored.

## Timing
- Synchronizer latency: 2 cycles from `din` to `ds`. Edge detection adds 1 cycle.
- `busy` rises the cycle after `start` is sampled.
- `valid` and the `data` update occur on the clk edge where STOP_RISE sees the stop-bit rising edge, i.e. 3 cycles after `din` rises.
- `busy` falls the cycle after `valid`/`err`; `valid` and `err` are never high together.
- The bit decision is made at the rising edge of the low pulse. The high-phase length does not affect the decoded value. It only counts toward `TIMEOUT`.
- Minimum supported bit period is 2·`GLITCH`+4 cycles.

## Test plan
- Arm, then drive 32 bits at 12 MHz encoding (0 = 36 low/12 high, 1 = 12 low/36 high) with value 0x80000001, then a stop bit of 24 low → `data`=0x80000001 and `valid` one cycle, exactly 3 cycles after the stop-bit rise; `busy` low the next cycle.
- Threshold boundary: a frame whose bit 31 has a 23-cycle low and bit 30 a 24-cycle low, rest 1 → `data`=0xBFFFFFFF.
- Glitch: insert a 2-cycle low pulse between bits 5 and 6 of 0xA5A5A5A5 → still decodes 0xA5A5A5A5.
- Timeout: arm and hold `din` high → `err` pulses once, `TIMEOUT`+1 cycles after `busy` rises; `data` keeps its previous value; `valid` stays 0.
- Reset mid-frame: assert `rstn`=0 for 1 cycle after 10 bits → all outputs 0 and state IDLE; a subsequent armed frame 0x12345678 decodes correctly.
- `start` pulsed again after bit 8 of 0x0000FFFF → ignored; frame decodes 0x0000FFFF with a single `valid`.

Source files
------------

// File: rtl/n64_rx_if.sv
// Bundle of the N64 receiver's arm/data-line inputs and its decoded-word outputs.
// The master drives arm and line, the slave (receiver) presents results.
interface n64_rx_if #(
    parameter int N = 32
) ();
    logic         start;
    logic         din;
    logic [N-1:0] data;
    logic         valid;
    logic         busy;
    logic         err;

    modport master (
        output start,
        output din,
        input  data,
        input  valid,
        input  busy,
        input  err
    );

    modport slave (
        input  start,
        input  din,
        output data,
        output valid,
        output busy,
        output err
    );
endinterface

// File: rtl/n64_rx.sv
// N64 controller response receiver: measures each low pulse on the single-wire
// line, deserializes N bits MSB-first, waits out the stop bit and strobes the word.
module n64_rx #(
    parameter int N       = 32,
    parameter int THRESH  = 24,
    parameter int GLITCH  = 3,
    parameter int TIMEOUT = 1200
) (
    input  logic     clk,
    input  logic     rstn,
    n64_rx_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        MEAS_LOW,
        STOP_FALL,
        STOP_RISE,
        ABORT
    } state_t;

    state_t         r_state;
    logic           r_sync1;
    logic           r_ds;
    logic           r_ds_d;
    logic [CW-1:0]  r_cnt;
    logic [BW-1:0]  r_bits;
    logic [N-1:0]   r_shift;
    logic [N-1:0]   r_data;
    logic           r_valid;
    logic           r_busy;
    logic           r_err;

    logic           w_fall;
    logic           w_rise;
    logic           w_tmo;
    logic           w_bit;
    logic           w_glitch;
    logic [CW-1:0]  w_cnt_inc;
    logic [BW-1:0]  w_bits_inc;

    assign w_fall     = r_ds_d & ~r_ds;
    assign w_rise     = ~r_ds_d & r_ds;
    assign w_tmo      = (r_cnt == CW'(TIMEOUT));
    assign w_cnt_inc  = w_tmo ? r_cnt : r_cnt + CW'(1);
    assign w_bit      = (r_cnt < CW'(THRESH));
    assign w_glitch   = (r_cnt < CW'(GLITCH));
    assign w_bits_inc = r_bits + BW'(1);

    assign bus.data  = r_data;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.err   = r_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_sync1 <= 1'b1;
            r_ds    <= 1'b1;
            r_ds_d  <= 1'b1;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= bus.din;
            r_ds    <= r_sync1;
            r_ds_d  <= r_ds;
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= WAIT_FALL;
                        r_cnt   <= '0;
                        r_bits  <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                WAIT_FALL: begin
                    if (w_fall) begin
                        r_state <= MEAS_LOW;
                        r_cnt   <= CW'(1);
                    end else if (w_tmo) begin
                        r_state <= ABORT;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                MEAS_LOW: begin
                    // The low width is final at the rising edge; high time only feeds the timeout.
                    if (w_rise) begin
                        r_cnt <= '0;
                        if (w_glitch) begin
                            r_state <= WAIT_FALL;
                        end else begin
                            r_shift <= {r_shift[N-2:0], w_bit};
                            r_bits  <= w_bits_inc;
                            r_state <= (w_bits_inc == BW'(N)) ? STOP_FALL : WAIT_FALL;
                        end
                    end else if (w_tmo) begin
                        r_state <= ABORT;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                STOP_FALL: begin
                    if (w_fall) begin
                        r_state <= STOP_RISE;
                        r_cnt   <= CW'(1);
                    end else if (w_tmo) begin
                        r_state <= ABORT;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                STOP_RISE: begin
                    // busy stays high through the valid cycle and drops from IDLE.
                    if (w_rise) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_tmo) begin
                        r_state <= ABORT;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ABORT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_n64_rx.sv
// Directed bench for n64_rx: expected words go into a scoreboard queue and a
// negedge monitor pops and compares them whenever valid strobes.
module tb_n64_rx;
    localparam int TIMEOUT = 1200;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    n64_rx_if #(.N(32)) ifc ();

    n64_rx #(
        .N       (32),
        .THRESH  (24),
        .GLITCH  (3),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end else begin
            $display("ok   %s value=0x%08h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ifc.valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=0x%08h required=no_frame", ifc.data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame_data", ifc.data, mon_exp);
                end
            end
            if (ifc.err) err_cnt++;
            if (ifc.valid && ifc.err) begin
                checks++;
                failures++;
                $display("FAIL valid_err_overlap actual=both_high required=exclusive");
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int lo, input int hi);
        ifc.din = 1'b0;
        tick(lo);
        ifc.din = 1'b1;
        tick(hi);
    endtask

    task automatic send_bits(input logic [31:0] w, input int hi_i, input int lo_i);
        for (int i = hi_i; i >= lo_i; i--) begin
            if (w[i]) pulse(12, 36);
            else      pulse(36, 12);
        end
    endtask

    task automatic arm();
        ifc.start = 1'b1;
        tick(1);
        ifc.start = 1'b0;
        tick(4);
    endtask

    // Stop bit, then count clk edges from the line rising to valid.
    task automatic stop_bit(input string name);
        int lat;
        ifc.din = 1'b0;
        tick(24);
        ifc.din = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifc.valid) begin
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        check({name, "_valid_latency"}, 32'(lat), 32'd3);
        check({name, "_busy_after"}, 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        int v0;
        int e0;
        int tlat;
        ifc.din   = 1'b1;
        ifc.start = 1'b0;
        tick(3);
        rstn = 1'b1;
        check("reset_data",  ifc.data,         32'h0);
        check("reset_valid", 32'(ifc.valid),   32'd0);
        check("reset_busy",  32'(ifc.busy),    32'd0);
        check("reset_err",   32'(ifc.err),     32'd0);

        // Nominal frame
        arm();
        check("armed_busy", 32'(ifc.busy), 32'd1);
        exp_q.push_back(32'h8000_0001);
        send_bits(32'h8000_0001, 31, 0);
        stop_bit("nominal");

        // Threshold boundary: 23 low -> 1, 24 low -> 0
        tick(5);
        arm();
        exp_q.push_back(32'hBFFF_FFFF);
        pulse(23, 25);
        pulse(24, 24);
        send_bits(32'hFFFF_FFFF, 29, 0);
        stop_bit("thresh");

        // Glitch pulse mid-frame is discarded
        tick(5);
        arm();
        exp_q.push_back(32'hA5A5_A5A5);
        send_bits(32'hA5A5_A5A5, 31, 6);
        pulse(2, 10);
        send_bits(32'hA5A5_A5A5, 5, 0);
        stop_bit("glitch");

        // Timeout with the line held high
        tick(5);
        v0 = valid_cnt;
        e0 = err_cnt;
        ifc.start = 1'b1;
        tick(1);
        ifc.start = 1'b0;
        tlat = 0;
        for (int i = 1; i <= TIMEOUT + 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifc.err) begin
                tlat = i;
                break;
            end
        end
        tick(10);
        check("timeout_err_latency", 32'(tlat), 32'(TIMEOUT + 1));
        check("timeout_err_pulses",  32'(err_cnt - e0), 32'd1);
        check("timeout_data_kept",   ifc.data, 32'hA5A5_A5A5);
        check("timeout_no_valid",    32'(valid_cnt - v0), 32'd0);
        check("timeout_busy_low",    32'(ifc.busy), 32'd0);

        // Reset after 10 bits, then a clean frame
        arm();
        send_bits(32'hDEAD_BEEF, 31, 22);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        check("midreset_data",  ifc.data,       32'h0);
        check("midreset_valid", 32'(ifc.valid), 32'd0);
        check("midreset_busy",  32'(ifc.busy),  32'd0);
        check("midreset_err",   32'(ifc.err),   32'd0);
        tick(60);
        check("midreset_still_idle", 32'(ifc.busy), 32'd0);
        arm();
        exp_q.push_back(32'h1234_5678);
        send_bits(32'h1234_5678, 31, 0);
        stop_bit("after_reset");

        // start re-pulsed while busy is ignored
        tick(5);
        v0 = valid_cnt;
        arm();
        exp_q.push_back(32'h0000_FFFF);
        send_bits(32'h0000_FFFF, 31, 24);
        ifc.start = 1'b1;
        tick(1);
        ifc.start = 1'b0;
        check("restart_busy_held", 32'(ifc.busy), 32'd1);
        send_bits(32'h0000_FFFF, 23, 0);
        stop_bit("restart");
        tick(20);
        check("restart_single_valid", 32'(valid_cnt - v0), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("total_err_pulses", 32'(err_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
